z80_bus_responder: RTL

Synthesizable memory/IO target for the tv80s core's external bus. It decodes `mreq_n`/`iorq_n`/`rd_n`/`wr_n`/`m1_n`/`rfsh_n`, serves reads from an internal RAM or IO register file, and commits writes. It generates `wait_n` with programmable wait states and answers interrupt-acknowledge cycles with a vector. It replaces behavioural memory models in CPU benches and serves as the on-chip RAM in small FPGA builds.

---
 rtl/z80_resp_pkg.sv | 52 +++++
 rtl/z80_bus_responder_if.sv | 28 ++
 rtl/z80_resp_ram.sv | 28 ++
 rtl/z80_bus_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/z80_resp_pkg.sv
// Shared types and bus-cycle decode for the z80_bus_responder slice.
package z80_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } state_t;

    typedef enum logic [2:0] {
        CYC_NONE,
        CYC_MEM_RD,
        CYC_MEM_WR,
        CYC_IO_RD,
        CYC_IO_WR,
        CYC_INTA
    } cycle_t;

    // Source of the byte presented on rdata after the last edge.
    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_MEM,
        SEL_IO,
        SEL_VEC
    } rd_sel_t;

    typedef struct packed {
        logic m1_n;
        logic mreq_n;
        logic iorq_n;
        logic rd_n;
        logic wr_n;
        logic rfsh_n;
    } strobes_t;

    // Interrupt acknowledge outranks memory, which outranks IO; refresh decodes to none.
    function automatic cycle_t decode_cycle(input strobes_t s);
        cycle_t c;
        c = CYC_NONE;
        if (!s.m1_n && !s.iorq_n) begin
            c = CYC_INTA;
        end else if (!s.mreq_n && s.rfsh_n && (!s.rd_n || !s.wr_n)) begin
            if (!s.rd_n) c = CYC_MEM_RD;
            else         c = CYC_MEM_WR;
        end else if (!s.iorq_n && s.m1_n && (!s.rd_n || !s.wr_n)) begin
            if (!s.rd_n) c = CYC_IO_RD;
            else         c = CYC_IO_WR;
        end
        return c;
    endfunction

endpackage

// File: rtl/z80_bus_responder_if.sv
// tv80s external bus plus backdoor load port, as seen by the responder.
interface z80_bus_if;
    logic [15:0] a;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic        wait_n;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;

    modport master (
        output a, wdata, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
        output ld_en, ld_addr, ld_data,
        input  rdata, wait_n
    );

    modport slave (
        input  a, wdata, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
        input  ld_en, ld_addr, ld_data,
        output rdata, wait_n
    );
endinterface

// File: rtl/z80_resp_ram.sv
// 2^ADDR_W x 8 RAM: registered read, bus write port and backdoor write port.
module z80_resp_ram #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [7:0]        wdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    // Read samples the pre-edge contents, so same-edge writes return the old byte.
    always_ff @(posedge clk) begin
        rdata <= mem[addr];
        if (we && !(ld_en && (ld_addr == addr))) begin
            mem[addr] <= wdata;
        end
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

endmodule

// File: rtl/z80_bus_responder.sv
// Memory/IO target for the tv80s bus: RAM, optional IO file, wait states, INTA vector.
// Define Z80_RESP_IO_EN to build the 256-byte IO register file.
module z80_bus_responder
    import z80_resp_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 0,
    parameter logic [7:0]  INT_VEC  = 8'hFF
) (
    input  logic   clk,
    input  logic   reset,
    z80_bus_if.slave bus
);

    localparam logic [3:0] MEM_N = 4'(MEM_WAIT);
    localparam logic [3:0] IO_N  = 4'(IO_WAIT);

    strobes_t   strb;
    cycle_t     cyc;
    logic       req;

    state_t     state_q, state_d;
    cycle_t     cyc_q, cyc_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       wait_n_q, wait_n_d;
    logic       mem_we;
`ifdef Z80_RESP_IO_EN
    logic       io_we;
`endif

    rd_sel_t    rd_sel_d, rd_sel_p1;
    logic [7:0] mem_rdata_p1;

    function automatic logic [3:0] wait_count(input cycle_t c);
        logic [3:0] n;
        n = 4'd0;
        if (c == CYC_MEM_RD || c == CYC_MEM_WR) n = MEM_N;
        else if (c == CYC_IO_RD || c == CYC_IO_WR) n = IO_N;
        return n;
    endfunction

    assign strb = '{m1_n:   bus.m1_n,
                    mreq_n: bus.mreq_n,
                    iorq_n: bus.iorq_n,
                    rd_n:   bus.rd_n,
                    wr_n:   bus.wr_n,
                    rfsh_n: bus.rfsh_n};
    assign cyc  = decode_cycle(strb);
    assign req  = (cyc != CYC_NONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cyc_q    <= CYC_NONE;
            cnt_q    <= 4'd0;
            done_q   <= 1'b0;
            wait_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            wait_n_q <= wait_n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        wait_n_d = wait_n_q;
        mem_we   = 1'b0;
`ifdef Z80_RESP_IO_EN
        io_we    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                done_d   = 1'b0;
                wait_n_d = 1'b1;
                if (req) begin
                    cyc_d = cyc;
                    if (wait_count(cyc) != 4'd0) begin
                        state_d  = ST_WAIT;
                        cnt_d    = wait_count(cyc) - 4'd1;
                        wait_n_d = 1'b0;
                    end else begin
                        state_d  = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                // A vanished strobe aborts the cycle; nothing is committed.
                if (!req) begin
                    state_d  = ST_IDLE;
                    cnt_d    = 4'd0;
                    wait_n_d = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d  = ST_ACCESS;
                    wait_n_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else if (!bus.wr_n && !done_q) begin
                    done_d = 1'b1;
                    mem_we = (cyc_q == CYC_MEM_WR);
`ifdef Z80_RESP_IO_EN
                    io_we  = (cyc_q == CYC_IO_WR);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_sel_d = SEL_MEM;
        if (cyc == CYC_INTA) rd_sel_d = SEL_VEC;
        else if (cyc == CYC_IO_RD || cyc == CYC_IO_WR) rd_sel_d = SEL_IO;
    end

    // Read stage p1: source select and storage read ports are captured every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_sel_p1 <= SEL_ZERO;
        else       rd_sel_p1 <= rd_sel_d;
    end

    z80_resp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .addr    (bus.a[ADDR_W-1:0]),
        .we      (mem_we),
        .wdata   (bus.wdata),
        .ld_en   (bus.ld_en),
        .ld_addr (bus.ld_addr[ADDR_W-1:0]),
        .ld_data (bus.ld_data),
        .rdata   (mem_rdata_p1)
    );

`ifdef Z80_RESP_IO_EN
    logic [7:0] io_mem [256];
    logic [7:0] io_rdata_p1;

    always_ff @(posedge clk) begin
        io_rdata_p1 <= io_mem[bus.a[7:0]];
        if (io_we) begin
            io_mem[bus.a[7:0]] <= bus.wdata;
        end
    end
`endif

    always_comb begin
        case (rd_sel_p1)
            SEL_MEM: bus.rdata = mem_rdata_p1;
`ifdef Z80_RESP_IO_EN
            SEL_IO:  bus.rdata = io_rdata_p1;
`else
            SEL_IO:  bus.rdata = 8'hFF;
`endif
            SEL_VEC: bus.rdata = INT_VEC;
            default: bus.rdata = 8'h00;
        endcase
    end

    assign bus.wait_n = wait_n_q;

endmodule
